data_mem_be: RTL and testbench

Parametrised successor to the stalling data memory on the processor's load/store path. It provides a byte-enable block RAM and single-cycle stores with no stall. Loads take a fixed one-cycle stall, with sign or zero extension. The block also adds misalignment detection, a resettable LED MMIO register with readback, and a synchronous active-low reset. It sits between the MEM stage and on-chip BRAM. It drives `clk_stall` back to the core, which freezes the pipeline while `clk_stall` is high.

---
 rtl/data_mem_pkg.sv | 68 ++++++
 rtl/data_mem_bram.sv | 31 +++
 rtl/data_mem_be.sv | 153 +++++++++++++++
 tb/tb_data_mem_be.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared encodings and lane helpers for the byte-enable data memory.
package data_mem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [2:0] SZ_BYTE = 3'b001;
    localparam logic [2:0] SZ_HALF = 3'b011;
    localparam logic [2:0] SZ_WORD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Any size code other than half/word is treated as a byte access.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (size == SZ_HALF) begin
            mis = off[0];
        end else if (size == SZ_WORD) begin
            mis = (off != 2'b00);
        end
        return mis;
    endfunction

    function automatic logic [BE_W-1:0] byte_en(input logic [2:0] size, input logic [1:0] off);
        logic [BE_W-1:0] be;
        case (size)
            SZ_WORD: be = 4'hF;
            SZ_HALF: be = 4'(4'b0011 << off);
            default: be = 4'(4'b0001 << off);
        endcase
        return be;
    endfunction

    // Right-aligned store data copied onto every lane it could land in.
    function automatic logic [WORD_W-1:0] lane_replicate(input logic [WORD_W-1:0] wd,
                                                         input logic [2:0] size);
        logic [WORD_W-1:0] r;
        case (size)
            SZ_WORD: r = wd;
            SZ_HALF: r = {2{wd[15:0]}};
            default: r = {4{wd[7:0]}};
        endcase
        return r;
    endfunction

    function automatic logic [WORD_W-1:0] load_extend(input logic [WORD_W-1:0] word,
                                                      input logic [1:0]        off,
                                                      input logic [2:0]        size,
                                                      input logic              sgn);
        logic [7:0]        b;
        logic [15:0]       h;
        logic [WORD_W-1:0] r;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_WORD: r = word;
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = {{24{sgn & b[7]}}, b};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_bram.sv
// Single-port byte-enable RAM with registered read; contents are never reset.
module data_mem_bram #(
    parameter  int unsigned DEPTH_WORDS = 1024,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Read-before-write on a shared port keeps this a single inferred BRAM.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < 4; b++) begin
                if (we[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_be.sv
// Load/store data memory: zero-stall stores, one-cycle-stall loads, LED MMIO, sticky misalign flag.
module data_mem_be
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] LED_ADDR    = 32'h2000,
    parameter int unsigned LED_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      addr,
    input  logic [31:0]      write_data,
    input  logic             memwrite,
    input  logic             memread,
    input  logic [3:0]       sign_mask,
    output logic [31:0]      read_data,
    output logic [LED_W-1:0] led,
    output logic             clk_stall,
    output logic             misalign_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_e           state_q,     state_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             clk_stall_q, clk_stall_d;
    logic [LED_W-1:0] led_q,       led_d;
    logic             mis_err_q,   mis_err_d;

    // Request attributes captured at load acceptance, used in READ.
    logic [1:0]       off_q,       off_d;
    logic [2:0]       size_q,      size_d;
    logic             sgn_q,       sgn_d;
    logic             mis_buf_q,   mis_buf_d;
    logic             led_hit_q,   led_hit_d;

    logic             ram_en_c;
    logic [3:0]       ram_we_c;
    logic [31:0]      ram_wdata_c;
    logic [AW-1:0]    ram_idx_c;
    logic [31:0]      ram_rdata;

    logic [2:0]       req_size_c;
    logic             req_mis_c;
    logic             req_led_c;

    assign req_size_c  = sign_mask[2:0];
    assign req_mis_c   = is_misaligned(req_size_c, addr[1:0]);
    assign req_led_c   = (addr == LED_ADDR);
    assign ram_idx_c   = addr[AW+1:2];
    assign ram_wdata_c = lane_replicate(write_data, req_size_c);

    data_mem_bram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_bram (
        .clk   (clk),
        .en    (ram_en_c),
        .we    (ram_we_c),
        .idx   (ram_idx_c),
        .wdata (ram_wdata_c),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        clk_stall_d = clk_stall_q;
        led_d       = led_q;
        mis_err_d   = mis_err_q;
        off_d       = off_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        mis_buf_d   = mis_buf_q;
        led_hit_d   = led_hit_q;
        ram_en_c    = 1'b0;
        ram_we_c    = 4'h0;

        case (state_q)
            ST_IDLE: begin
                if (memread) begin
                    ram_en_c    = 1'b1;
                    off_d       = addr[1:0];
                    size_d      = req_size_c;
                    sgn_d       = sign_mask[3];
                    mis_buf_d   = req_mis_c;
                    led_hit_d   = req_led_c;
                    mis_err_d   = mis_err_q | req_mis_c;
                    clk_stall_d = 1'b1;
                    state_d     = ST_READ;
                end else if (memwrite) begin
                    if (req_mis_c) begin
                        mis_err_d = 1'b1;
                    end else if (req_led_c) begin
                        led_d = write_data[LED_W-1:0];
                    end else begin
                        ram_en_c = 1'b1;
                        ram_we_c = byte_en(req_size_c, addr[1:0]);
                    end
                end
            end
            ST_READ: begin
                if (mis_buf_q) begin
                    read_data_d = 32'h0;
                end else if (led_hit_q) begin
                    read_data_d = 32'(led_q);
                end else begin
                    read_data_d = load_extend(ram_rdata, off_q, size_q, sgn_q);
                end
                clk_stall_d = 1'b0;
                state_d     = ST_DONE;
            end
            // The core still presents the request it was stalled on; drop it.
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            read_data_q <= 32'h0;
            clk_stall_q <= 1'b0;
            led_q       <= '0;
            mis_err_q   <= 1'b0;
            off_q       <= 2'b00;
            size_q      <= SZ_BYTE;
            sgn_q       <= 1'b0;
            mis_buf_q   <= 1'b0;
            led_hit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
            clk_stall_q <= clk_stall_d;
            led_q       <= led_d;
            mis_err_q   <= mis_err_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            mis_buf_q   <= mis_buf_d;
            led_hit_q   <= led_hit_d;
        end
    end

    assign read_data    = read_data_q;
    assign led          = led_q;
    assign clk_stall    = clk_stall_q;
    assign misalign_err = mis_err_q;

endmodule

// File: tb/tb_data_mem_be.sv
// Bench for data_mem_be: directed vector table, corner sequences, and random ops against a byte-array model.
module tb_data_mem_be;

    localparam int unsigned DEPTH    = 1024;
    localparam logic [31:0] LED_ADDR = 32'h2000;
    localparam int unsigned LED_W    = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0]      addr = 32'h0;
    logic [31:0]      write_data = 32'h0;
    logic             memwrite = 1'b0;
    logic             memread = 1'b0;
    logic [3:0]       sign_mask = 4'h0;
    logic [31:0]      read_data;
    logic [LED_W-1:0] led;
    logic             clk_stall;
    logic             misalign_err;

    data_mem_be #(
        .DEPTH_WORDS (DEPTH),
        .LED_ADDR    (LED_ADDR),
        .LED_W       (LED_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr         (addr),
        .write_data   (write_data),
        .memwrite     (memwrite),
        .memread      (memread),
        .sign_mask    (sign_mask),
        .read_data    (read_data),
        .led          (led),
        .clk_stall    (clk_stall),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: byte-addressed memory, LED value, sticky error.
    logic [7:0] mm [DEPTH*4];
    logic [7:0] led_m = 8'h0;
    logic       err_m = 1'b0;

    localparam logic [3:0] SM_B  = 4'b0001;
    localparam logic [3:0] SM_BS = 4'b1001;
    localparam logic [3:0] SM_H  = 4'b0011;
    localparam logic [3:0] SM_HS = 4'b1011;
    localparam logic [3:0] SM_W  = 4'b0111;

    typedef struct {
        bit          is_ld;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  sm;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [7:0]  exp_led;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned nbytes(input logic [3:0] sm);
        if (sm[2:0] == 3'b111) return 4;
        if (sm[2:0] == 3'b011) return 2;
        return 1;
    endfunction

    function automatic bit model_mis(input logic [31:0] a, input logic [3:0] sm);
        int unsigned n = nbytes(sm);
        return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    endfunction

    function automatic int unsigned bidx(input logic [31:0] a);
        int unsigned ua = a;
        return ((ua / 4) % DEPTH) * 4 + (ua % 4);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] sm);
        int unsigned       n = nbytes(sm);
        int unsigned       base;
        longint unsigned   v = 0;
        if (model_mis(a, sm)) return 32'h0;
        if (a == LED_ADDR) return {24'h0, led_m};
        base = bidx(a);
        for (int i = 0; i < int'(n); i++) v = v | (longint'(mm[base + i]) << (8 * i));
        if (sm[3] && ((v >> (8 * n - 1)) & 1) == 1) v = v | ~((64'd1 << (8 * n)) - 1);
        return v[31:0];
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sm);
        int unsigned n = nbytes(sm);
        int unsigned base;
        if (model_mis(a, sm)) begin
            err_m = 1'b1;
            return;
        end
        if (a == LED_ADDR) begin
            led_m = wd[7:0];
            return;
        end
        base = bidx(a);
        for (int i = 0; i < int'(n); i++) mm[base + i] = 8'(wd >> (8 * i));
    endfunction

    task automatic do_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sm);
        @(negedge clk);
        memread = 1'b0; memwrite = 1'b1;
        addr = a; write_data = wd; sign_mask = sm;
        @(posedge clk); #1;
        chk("store_nostall", {31'h0, clk_stall}, 32'h0);
        model_store(a, wd, sm);
    endtask

    // Request stays asserted through DONE, as a stalled core would present it.
    task automatic do_load(input logic [31:0] a, input logic [3:0] sm, input logic wr_also,
                           input logic [31:0] exp);
        @(negedge clk);
        memread = 1'b1; memwrite = wr_also;
        addr = a; write_data = $urandom; sign_mask = sm;
        @(posedge clk); #1;
        chk("load_stall_e0", {31'h0, clk_stall}, 32'h1);
        @(posedge clk); #1;
        chk("load_stall_e1", {31'h0, clk_stall}, 32'h0);
        chk("load_data", read_data, exp);
        @(posedge clk); #1;
        chk("load_nostall_done", {31'h0, clk_stall}, 32'h0);
        chk("load_data_hold", read_data, exp);
        if (model_mis(a, sm)) err_m = 1'b1;
    endtask

    task automatic do_idle();
        @(negedge clk);
        memread = 1'b0; memwrite = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic vec_t mk(input bit ld, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] sm, input logic [31:0] rd,
                                input logic er, input logic [7:0] ld_led);
        vec_t v;
        v.is_ld = ld; v.a = a; v.wd = wd; v.sm = sm;
        v.exp_rd = rd; v.exp_err = er; v.exp_led = ld_led;
        return v;
    endfunction

    initial begin
        logic [31:0] exp;

        // Reset held for two cycles.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_clk_stall", {31'h0, clk_stall}, 32'h0);
        chk("rst_led", {24'h0, led}, 32'h0);
        chk("rst_misalign", {31'h0, misalign_err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Known contents everywhere: word i = C0DE_iiii.
        for (int i = 0; i < int'(DEPTH); i++) do_store(32'(i * 4), {16'hC0DE, 16'(i)}, SM_W);

        vecs.push_back(mk(0, 32'h10,   32'hDEADBEEF, SM_W,  32'h0,        0, 8'h00));
        vecs.push_back(mk(1, 32'h13,   32'h0,        SM_BS, 32'hFFFFFFDE, 0, 8'h00));
        vecs.push_back(mk(1, 32'h12,   32'h0,        SM_H,  32'h0000DEAD, 0, 8'h00));
        vecs.push_back(mk(1, 32'h12,   32'h0,        SM_HS, 32'hFFFFDEAD, 0, 8'h00));
        vecs.push_back(mk(1, 32'h10,   32'h0,        SM_B,  32'h000000EF, 0, 8'h00));
        vecs.push_back(mk(0, 32'h11,   32'h1234565A, SM_B,  32'h0,        0, 8'h00));
        vecs.push_back(mk(1, 32'h10,   32'h0,        SM_W,  32'hDEAD5AEF, 0, 8'h00));
        vecs.push_back(mk(0, 32'h16,   32'h00008001, SM_H,  32'h0,        0, 8'h00));
        vecs.push_back(mk(1, 32'h14,   32'h0,        SM_W,  32'h80010005, 0, 8'h00));
        vecs.push_back(mk(0, LED_ADDR, 32'h000000A5, SM_W,  32'h0,        0, 8'hA5));
        vecs.push_back(mk(1, 32'h0,    32'h0,        SM_W,  32'hC0DE0000, 0, 8'hA5));
        vecs.push_back(mk(1, LED_ADDR, 32'h0,        SM_W,  32'h000000A5, 0, 8'hA5));
        vecs.push_back(mk(1, LED_ADDR, 32'h0,        SM_BS, 32'h000000A5, 0, 8'hA5));
        vecs.push_back(mk(1, 32'h1010, 32'h0,        SM_W,  32'hDEAD5AEF, 0, 8'hA5));
        vecs.push_back(mk(0, 32'h21,   32'h0000FFFF, SM_H,  32'h0,        1, 8'hA5));
        vecs.push_back(mk(1, 32'h20,   32'h0,        SM_W,  32'hC0DE0008, 1, 8'hA5));
        vecs.push_back(mk(1, 32'h22,   32'h0,        SM_W,  32'h00000000, 1, 8'hA5));

        foreach (vecs[k]) begin
            if (vecs[k].is_ld) do_load(vecs[k].a, vecs[k].sm, 1'b0, vecs[k].exp_rd);
            else               do_store(vecs[k].a, vecs[k].wd, vecs[k].sm);
            chk($sformatf("vec%0d_misalign", k), {31'h0, misalign_err}, {31'h0, vecs[k].exp_err});
            chk($sformatf("vec%0d_led", k), {24'h0, led}, {24'h0, vecs[k].exp_led});
        end
        do_idle();

        // Back-to-back stores, then held-request loads.
        do_store(32'h0, 32'h11111111, SM_W);
        do_store(32'h4, 32'h22222222, SM_W);
        do_store(32'h8, 32'h33333333, SM_W);
        do_store(32'hC, 32'h44444444, SM_W);
        do_load(32'h0, SM_W, 1'b0, 32'h11111111);
        do_load(32'h4, SM_W, 1'b0, 32'h22222222);
        do_load(32'h8, SM_W, 1'b0, 32'h33333333);
        do_load(32'hC, SM_W, 1'b0, 32'h44444444);
        do_idle();
        chk("b2b_no_extra_stall", {31'h0, clk_stall}, 32'h0);

        // Reset during READ abandons the load.
        @(negedge clk);
        memread = 1'b1; memwrite = 1'b0; addr = 32'h10; sign_mask = SM_W;
        @(posedge clk); #1;
        chk("midrst_stall_e0", {31'h0, clk_stall}, 32'h1);
        @(negedge clk);
        rst_n = 1'b0; memread = 1'b0;
        @(posedge clk); #1;
        chk("midrst_stall", {31'h0, clk_stall}, 32'h0);
        chk("midrst_read_data", read_data, 32'h0);
        chk("midrst_led", {24'h0, led}, 32'h0);
        chk("midrst_misalign", {31'h0, misalign_err}, 32'h0);
        led_m = 8'h0; err_m = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_idle_stall", {31'h0, clk_stall}, 32'h0);
        chk("midrst_idle_rd", read_data, 32'h0);
        do_load(32'h10, SM_W, 1'b0, 32'hDEAD5AEF);

        // Random mix checked against the byte-array model.
        for (int t = 0; t < 400; t++) begin
            logic [31:0] a;
            logic [3:0]  sm;
            int unsigned kind = $urandom_range(0, 9);
            int unsigned szs  = $urandom_range(0, 2);
            sm = {1'($urandom_range(0, 1)), (szs == 0) ? 3'b001 : (szs == 1) ? 3'b011 : 3'b111};
            if (kind == 0)      a = LED_ADDR;
            else if (kind == 1) a = 32'($urandom_range(1, 3) * DEPTH * 4 + $urandom_range(0, 63));
            else                a = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                exp = model_load(a, sm);
                do_load(a, sm, 1'($urandom_range(0, 3) == 0), exp);
            end else begin
                do_store(a, $urandom, sm);
            end
            chk("rand_misalign", {31'h0, misalign_err}, {31'h0, err_m});
            chk("rand_led", {24'h0, led}, {24'h0, led_m});
        end
        do_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
